serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor computing diff = a - b, one bit per clock, LSB first.
- Built around a registered borrow bit and a single full-subtractor cell. It is the inverse-direction companion to the team's combinational full adder.
- Intended for area-constrained datapaths. A start/done handshake lets a controller FSM issue operations.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 18 +
 rtl/serial_subtractor.sv | 133 +++++++++++++
 tb/tb_serial_subtractor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: computes x - y - bin.
// The difference bit comes out on d_o and the borrow on bout_o.
module full_subtractor
  import serial_sub_pkg::*;
(
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  // Difference bit is odd parity. A borrow is produced when y exceeds x,
  // or when x equals y and a borrow is already pending.
  assign d_o    = x_i ^ y_i ^ bin_i;
  assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first.
// Each operation takes one bit per clock and uses one shared full_subtractor
// cell together with a registered borrow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
)
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_out_o,
  output logic             overflow_o
);

  localparam int             CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  aSh_q, aSh_d;
  logic [WIDTH-1:0]  bSh_q, bSh_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              borrow_q, borrow_d;
  logic              borrowOut_q, borrowOut_d;
  logic              overflow_q, overflow_d;
  logic              aMsb_q, aMsb_d;
  logic              bMsb_q, bMsb_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              cellD;
  logic              cellBout;

  full_subtractor uCell (
    .x_i    (aSh_q[0]),
    .y_i    (bSh_q[0]),
    .bin_i  (borrow_q),
    .d_o    (cellD),
    .bout_o (cellBout)
  );

  // Next-state logic. Operands are captured only on a start accepted in IDLE.
  // The result is shifted in from the MSB while in RUN. The visible outputs
  // change only at the final RUN edge, so a partial result is never exposed.
  always_comb begin
    state_d     = state_q;
    aSh_d       = aSh_q;
    bSh_d       = bSh_q;
    res_d       = res_q;
    diff_d      = diff_q;
    borrow_d    = borrow_q;
    borrowOut_d = borrowOut_q;
    overflow_d  = overflow_q;
    aMsb_d      = aMsb_q;
    bMsb_d      = bMsb_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          aSh_d    = a_i;
          bSh_d    = b_i;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          aMsb_d   = a_i[WIDTH-1];
          bMsb_d   = b_i[WIDTH-1];
          state_d  = RUN;
        end
      end
      RUN: begin
        borrow_d = cellBout;
        res_d    = {cellD, res_q[WIDTH-1:1]};
        aSh_d    = {1'b0, aSh_q[WIDTH-1:1]};
        bSh_d    = {1'b0, bSh_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d     = DONE;
          diff_d      = {cellD, res_q[WIDTH-1:1]};
          borrowOut_d = cellBout;
          overflow_d  = (aMsb_q != bMsb_q) && (cellD != aMsb_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Synchronous reset clears everything and aborts any
  // operation in progress.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      aSh_q       <= '0;
      bSh_q       <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      borrowOut_q <= 1'b0;
      overflow_q  <= 1'b0;
      aMsb_q      <= 1'b0;
      bMsb_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      aSh_q       <= aSh_d;
      bSh_q       <= bSh_d;
      res_q       <= res_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      borrowOut_q <= borrowOut_d;
      overflow_q  <= overflow_d;
      aMsb_q      <= aMsb_d;
      bMsb_q      <= bMsb_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy_o       = (state_q == RUN);
  assign done_o       = (state_q == DONE);
  assign diff_o       = diff_q;
  assign borrow_out_o = borrowOut_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=8 and WIDTH=4) and full_subtractor.
// Expected results come from an arithmetic reference model. They are queued
// when an operation is issued and checked when done pulses.
module tb_serial_subtractor;

  localparam int W8 = 8;
  localparam int W4 = 4;

  typedef struct {
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, busy, done, borrowOut, overflow;
  logic [7:0] a, b, diff;
  logic       start4, busy4, done4, borrow4, ovf4;
  logic [3:0] a4, b4, diff4;
  logic       fsX, fsY, fsBin, fsD, fsBout;

  exp_t        sb8[$];
  exp_t        sb4[$];
  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [31:0] lastDiff8;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W8)) dut8 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .diff_o(diff),
    .borrow_out_o(borrowOut), .overflow_o(overflow)
  );

  serial_subtractor #(.WIDTH(W4)) dut4 (
    .clk_i(clk), .reset_i(reset), .start_i(start4), .a_i(a4), .b_i(b4),
    .busy_o(busy4), .done_o(done4), .diff_o(diff4),
    .borrow_out_o(borrow4), .overflow_o(ovf4)
  );

  full_subtractor fsU (
    .x_i(fsX), .y_i(fsY), .bin_i(fsBin), .d_o(fsD), .bout_o(fsBout)
  );

  // Reference arithmetic: modulo difference, unsigned borrow, signed range overflow
  function automatic exp_t model(input int unsigned x, input int unsigned y, input int w);
    exp_t m;
    int half, full, sx, sy, r;
    half = 1 << (w - 1);
    full = 1 << w;
    sx = (x >= 32'(half)) ? int'(x) - full : int'(x);
    sy = (y >= 32'(half)) ? int'(y) - full : int'(y);
    r  = sx - sy;
    m.diff   = (x - y) & 32'(full - 1);
    m.borrow = (x < y);
    m.ovf    = (r > half - 1) || (r < -half);
    return m;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on the 8-bit instance; returns just after the start edge
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    sb8.push_back(model(32'(av), 32'(bv), W8));
    tick();
  endtask

  // Called just after a start edge: follows RUN with a bounded wait, then checks the result
  task automatic waitDone8(input string tag);
    int   cycles;
    exp_t e;
    cycles = 0;
    while (!done && cycles < W8 + 4) begin
      checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
      checkOutput({tag, ".hold"}, 32'(diff), lastDiff8);
      tick();
      cycles++;
    end
    checkOutput({tag, ".latency"}, 32'(cycles), 32'(W8));
    checkOutput({tag, ".done"}, 32'(done), 32'd1);
    checkOutput({tag, ".busyLow"}, 32'(busy), 32'd0);
    if (sb8.size() == 0) begin
      testsRun++;
      testsFailed++;
      $error("[TB] FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb8.pop_front();
      checkOutput({tag, ".diff"}, 32'(diff), e.diff);
      checkOutput({tag, ".borrow"}, 32'(borrowOut), 32'(e.borrow));
      checkOutput({tag, ".ovf"}, 32'(overflow), 32'(e.ovf));
      lastDiff8 = e.diff;
    end
    tick();
    checkOutput({tag, ".donePulse"}, 32'(done), 32'd0);
    checkOutput({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  task automatic waitDone4(input string tag);
    int   cycles;
    exp_t e;
    cycles = 0;
    while (!done4 && cycles < W4 + 4) begin
      tick();
      cycles++;
    end
    checkOutput({tag, ".latency"}, 32'(cycles), 32'(W4));
    e = sb4.pop_front();
    checkOutput({tag, ".diff"}, 32'(diff4), e.diff);
    checkOutput({tag, ".borrow"}, 32'(borrow4), 32'(e.borrow));
    checkOutput({tag, ".ovf"}, 32'(ovf4), 32'(e.ovf));
    tick();
    checkOutput({tag, ".donePulse"}, 32'(done4), 32'd0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t dropped;
    int   doneSeen;
    int   r;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    fsX = 1'b0; fsY = 1'b0; fsBin = 1'b0;
    lastDiff8 = '0;
    tick();
    tick();
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.diff", 32'(diff), 32'd0);
    checkOutput("reset.borrow", 32'(borrowOut), 32'd0);
    checkOutput("reset.ovf", 32'(overflow), 32'd0);
    checkOutput("reset.busy4", 32'(busy4), 32'd0);
    reset = 1'b0;
    tick();

    // Exhaustive check of the standalone cell
    for (int i = 0; i < 8; i++) begin
      {fsX, fsY, fsBin} = 3'(i);
      #1;
      r = int'(fsX) - int'(fsY) - int'(fsBin);
      checkOutput($sformatf("cell%0d.d", i), 32'(fsD), 32'(r & 1));
      checkOutput($sformatf("cell%0d.bout", i), 32'(fsBout), 32'(r < 0));
    end

    // Directed operations, including borrow and both overflow directions
    applyStimulus(8'h05, 8'h03); start = 1'b0; waitDone8("op5m3");
    applyStimulus(8'h03, 8'h05); start = 1'b0; waitDone8("op3m5");
    applyStimulus(8'h80, 8'h01); start = 1'b0; waitDone8("op80m01");
    applyStimulus(8'h7F, 8'hFF); start = 1'b0; waitDone8("op7FmFF");
    applyStimulus(8'hA5, 8'hA5); start = 1'b0; waitDone8("opA5mA5");
    applyStimulus(8'h00, 8'h01); start = 1'b0; waitDone8("op00m01");

    // Start held high while operands change mid-run; restart must wait WIDTH+2 edges
    applyStimulus(8'h10, 8'h01);
    a = 8'hFF;
    b = 8'hFF;
    waitDone8("hold1");
    sb8.push_back(model(32'hFF, 32'hFF, W8));
    tick();
    checkOutput("hold.restart", 32'(busy), 32'd1);
    start = 1'b0;
    waitDone8("hold2");

    // Reset four cycles into RUN aborts the operation with no done pulse
    applyStimulus(8'h33, 8'h11);
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort.busy", 32'(busy), 32'd0);
    checkOutput("abort.done", 32'(done), 32'd0);
    checkOutput("abort.diff", 32'(diff), 32'd0);
    checkOutput("abort.borrow", 32'(borrowOut), 32'd0);
    checkOutput("abort.ovf", 32'(overflow), 32'd0);
    dropped = sb8.pop_back();
    lastDiff8 = '0;
    doneSeen = 0;
    repeat (W8 + 4) begin
      if (done) doneSeen++;
      tick();
    end
    checkOutput("abort.noDone", 32'(doneSeen), 32'd0);
    applyStimulus(8'h40, 8'h41); start = 1'b0; waitDone8("afterAbort");

    // Reset wins over a simultaneous start
    a = 8'h22; b = 8'h11; start = 1'b1; reset = 1'b1;
    tick();
    checkOutput("rstStart.busy", 32'(busy), 32'd0);
    reset = 1'b0; start = 1'b0;
    tick();
    checkOutput("rstStart.busyAfter", 32'(busy), 32'd0);
    checkOutput("rstStart.done", 32'(done), 32'd0);
    checkOutput("rstStart.diff", 32'(diff), 32'd0);

    // Every operand pair on the 4-bit instance
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a4 = 4'(i);
        b4 = 4'(j);
        start4 = 1'b1;
        sb4.push_back(model(32'(i), 32'(j), W4));
        tick();
        start4 = 1'b0;
        waitDone4($sformatf("w4_%0h_%0h", i, j));
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
